picoblaze_led_port: RTL and testbench

Memory-mapped LED output peripheral on the Picoblaze output-port bus, directly downstream of the processor core inside `basic`, and the sole driver of the top-level `LEDS[7:0]` pins. Firmware writes either a direct on/off pattern or per-LED 8-bit brightness duties. The block generates glitch-free PWM from a prescaled counter, with duty changes double-buffered to the PWM period boundary. Every register reads back through `IN_PORT`.

---
 rtl/picoblaze_pkg.sv | 10 +
 rtl/pwm_timebase.sv | 37 +++
 rtl/picoblaze_led_port.sv | 111 +++++++++++
 tb/tb_picoblaze_led_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/picoblaze_pkg.sv
// Shared constants for Picoblaze output-port peripherals.
// Holds the register map of the LED port.
package picoblaze_pkg;

   localparam logic [7:0] LED_CTRL     = 8'd0;
   localparam logic [7:0] LED_DIRECT   = 8'd1;
   localparam logic [7:0] LED_DUTY0    = 8'd2;
   localparam logic [7:0] LED_NUM_REGS = 8'd10;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler that yields a tick every PRESCALE clocks, and an 8-bit period counter.
// Reusable by any peripheral that needs an 8-bit PWM counter.
module pwm_timebase #(
   parameter int unsigned PRESCALE = 16
) (
   input  logic       CLK_IN,
   input  logic       RESET_IN,
   output logic       tick,
   output logic [7:0] pwm_cnt,
   output logic       wrap
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;

   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
      wrap    = tick & (cnt_q == 8'hFF);
      pwm_cnt = cnt_q;
   end

   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         presc_q <= '0;
         cnt_q   <= 8'h00;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/picoblaze_led_port.sv
// LED output peripheral on the Picoblaze port bus: direct pattern or per-LED PWM brightness,
// with duty values double-buffered into shadow registers at each PWM period wrap.
module picoblaze_led_port
   import picoblaze_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR = 8'h80,
   parameter int unsigned PRESCALE  = 16
) (
   input  logic       CLK_IN,
   input  logic       RESET_IN,
   input  logic [7:0] PORT_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       WRITE_STROBE,
   input  logic       READ_STROBE,
   output logic [7:0] IN_PORT,
   output logic [7:0] LEDS
);

   logic       ctrl_q, ctrl_d;
   logic [7:0] direct_q, direct_d;
   logic [7:0] duty_q [8];
   logic [7:0] duty_d [8];
   logic [7:0] shadow_q [8];
   logic [7:0] shadow_d [8];
   logic [7:0] leds_q, leds_d;
   logic [7:0] in_port_q, in_port_d;

   logic [7:0] offset;
   logic [2:0] duty_idx;
   logic       in_range;
   logic       wr_en;
   logic [7:0] pwm_raw;
   logic [7:0] pwm_cnt;
   logic       wrap;
   logic       unused_tick;
   logic       unused_read;

   assign unused_read = READ_STROBE;

   pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .CLK_IN   (CLK_IN),
      .RESET_IN (RESET_IN),
      .tick     (unused_tick),
      .pwm_cnt  (pwm_cnt),
      .wrap     (wrap)
   );

   always_comb begin
      offset   = PORT_ID - BASE_ADDR;
      in_range = (offset < LED_NUM_REGS);
      duty_idx = 3'(offset - LED_DUTY0);
      wr_en    = WRITE_STROBE & in_range;

      ctrl_d   = ctrl_q;
      direct_d = direct_q;
      duty_d   = duty_q;
      if (wr_en) begin
         if (offset == LED_CTRL) begin
            ctrl_d = OUT_PORT[0];
         end else if (offset == LED_DIRECT) begin
            direct_d = OUT_PORT;
         end else begin
            duty_d[duty_idx] = OUT_PORT;
         end
      end

      // Copy from duty_q so a write on the wrap edge waits a full period.
      shadow_d = wrap ? duty_q : shadow_q;

      for (int i = 0; i < 8; i++) begin
         pwm_raw[i] = (shadow_q[i] == 8'hFF) | (pwm_cnt < shadow_q[i]);
      end
      leds_d = ctrl_q ? pwm_raw : direct_q;

      // Readback uses next-state values so a same-edge write reads back new data.
      in_port_d = 8'h00;
      if (in_range) begin
         if (offset == LED_CTRL) begin
            in_port_d = {7'b0, ctrl_d};
         end else if (offset == LED_DIRECT) begin
            in_port_d = direct_d;
         end else begin
            in_port_d = duty_d[duty_idx];
         end
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         ctrl_q    <= 1'b0;
         direct_q  <= 8'h00;
         duty_q    <= '{default: 8'h00};
         shadow_q  <= '{default: 8'h00};
         leds_q    <= 8'h00;
         in_port_q <= 8'h00;
      end else begin
         ctrl_q    <= ctrl_d;
         direct_q  <= direct_d;
         duty_q    <= duty_d;
         shadow_q  <= shadow_d;
         leds_q    <= leds_d;
         in_port_q <= in_port_d;
      end
   end

   assign LEDS    = leds_q;
   assign IN_PORT = in_port_q;

endmodule

// File: tb/tb_picoblaze_led_port.sv
// Self-checking bench for picoblaze_led_port with PRESCALE=1 so one PWM count per clock.
// Inputs driven and outputs sampled on the falling edge.
module tb_picoblaze_led_port;

   logic       CLK_IN = 1'b0;
   logic       RESET_IN;
   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       WRITE_STROBE;
   logic       READ_STROBE;
   logic [7:0] IN_PORT;
   logic [7:0] LEDS;

   int n_chk  = 0;
   int n_fail = 0;
   int k      = 0;   // non-reset rising edges since last reset; PWM count model is k mod 256
   int hi [8];

   typedef struct {
      logic [7:0] port;
      logic [7:0] data;
      logic       wr;
      logic [7:0] exp_leds;
      logic [7:0] exp_in;
   } vec_t;

   vec_t vecs [13];

   picoblaze_led_port #(
      .BASE_ADDR (8'h80),
      .PRESCALE  (1)
   ) dut (
      .CLK_IN       (CLK_IN),
      .RESET_IN     (RESET_IN),
      .PORT_ID      (PORT_ID),
      .OUT_PORT     (OUT_PORT),
      .WRITE_STROBE (WRITE_STROBE),
      .READ_STROBE  (READ_STROBE),
      .IN_PORT      (IN_PORT),
      .LEDS         (LEDS)
   );

   always #5 CLK_IN = ~CLK_IN;

   always @(posedge CLK_IN) begin
      if (RESET_IN) k <= 0;
      else          k <= k + 1;
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_k(input int target);
      int guard = 0;
      while (k < target && guard < 5000) begin
         @(negedge CLK_IN);
         guard++;
      end
      if (k != target) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_k: at edge %0d, expected %0d", k, target);
      end
   endtask

   task automatic wr(input logic [7:0] port, input logic [7:0] data);
      @(negedge CLK_IN);
      PORT_ID      = port;
      OUT_PORT     = data;
      WRITE_STROBE = 1'b1;
      @(negedge CLK_IN);
      WRITE_STROBE = 1'b0;
   endtask

   // Counts high samples per LED over 256 cycles starting at edge count 'start'; optionally
   // performs one write landing on rising edge 'wr_at'.
   task automatic run_window(input int start, input bit do_wr, input int wr_at,
                             input logic [7:0] wp, input logic [7:0] wd);
      wait_k(start);
      for (int i = 0; i < 8; i++) hi[i] = 0;
      for (int n = 0; n < 256; n++) begin
         for (int i = 0; i < 8; i++) if (LEDS[i] === 1'b1) hi[i]++;
         if (do_wr && k == wr_at - 1) begin
            PORT_ID      = wp;
            OUT_PORT     = wd;
            WRITE_STROBE = 1'b1;
         end else begin
            WRITE_STROBE = 1'b0;
         end
         @(negedge CLK_IN);
      end
      WRITE_STROBE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'h81, 8'hA5, 1'b1, 8'h00, 8'hA5};
      vecs[1]  = '{8'h81, 8'h00, 1'b0, 8'hA5, 8'hA5};
      vecs[2]  = '{8'h7F, 8'hFF, 1'b1, 8'hA5, 8'h00};
      vecs[3]  = '{8'h8A, 8'hFF, 1'b1, 8'hA5, 8'h00};
      vecs[4]  = '{8'h80, 8'h00, 1'b0, 8'hA5, 8'h00};
      vecs[5]  = '{8'h81, 8'h00, 1'b0, 8'hA5, 8'hA5};
      vecs[6]  = '{8'h89, 8'h00, 1'b0, 8'hA5, 8'h00};
      vecs[7]  = '{8'h80, 8'hFE, 1'b1, 8'hA5, 8'h00};
      vecs[8]  = '{8'h82, 8'h37, 1'b1, 8'hA5, 8'h37};
      vecs[9]  = '{8'h82, 8'h00, 1'b1, 8'hA5, 8'h00};
      vecs[10] = '{8'h8B, 8'h00, 1'b0, 8'hA5, 8'h00};
      vecs[11] = '{8'h81, 8'h3C, 1'b1, 8'hA5, 8'h3C};
      vecs[12] = '{8'h80, 8'h00, 1'b0, 8'h3C, 8'h00};

      RESET_IN     = 1'b1;
      PORT_ID      = 8'h00;
      OUT_PORT     = 8'h00;
      WRITE_STROBE = 1'b0;
      READ_STROBE  = 1'b0;
      repeat (3) @(negedge CLK_IN);
      check8("por_leds", LEDS, 8'h00);
      check8("por_in_port", IN_PORT, 8'h00);
      RESET_IN = 1'b0;

      // Register access, decode and direct-mode latency
      for (int v = 0; v < 13; v++) begin
         PORT_ID      = vecs[v].port;
         OUT_PORT     = vecs[v].data;
         WRITE_STROBE = vecs[v].wr;
         @(negedge CLK_IN);
         check8($sformatf("vec%0d_leds", v), LEDS, vecs[v].exp_leds);
         check8($sformatf("vec%0d_in_port", v), IN_PORT, vecs[v].exp_in);
      end
      WRITE_STROBE = 1'b0;

      // Mid-period reset with DIRECT still reading back 3C
      PORT_ID  = 8'h81;
      RESET_IN = 1'b1;
      repeat (10) @(negedge CLK_IN);
      check8("rst_leds", LEDS, 8'h00);
      check8("rst_in_port", IN_PORT, 8'h00);
      RESET_IN = 1'b0;
      check_int("rst_pwm_cnt", int'(dut.pwm_cnt), 0);
      PORT_ID = 8'h89;
      @(negedge CLK_IN);
      check8("rst_duty7_rb", IN_PORT, 8'h00);
      PORT_ID = 8'h81;
      @(negedge CLK_IN);
      check8("rst_direct_rb", IN_PORT, 8'h00);

      // PWM setup, all landing well before the first wrap at edge 256
      wr(8'h80, 8'h01);
      wr(8'h89, 8'h80);
      wr(8'h82, 8'hFF);
      wr(8'h83, 8'h00);
      wr(8'h85, 8'h40);

      run_window(257, 1'b0, 0, 8'h00, 8'h00);
      check_int("p1_led7_high", hi[7], 128);
      check_int("p1_led0_high", hi[0], 256);
      check_int("p1_led1_high", hi[1], 0);
      check_int("p1_led3_high", hi[3], 64);

      // Double buffering: mid-period write, then a write on the wrap edge itself
      run_window(513, 1'b1, 600, 8'h85, 8'hC0);
      check_int("p2_led3_mid_write", hi[3], 64);
      run_window(769, 1'b1, 1024, 8'h85, 8'h40);
      check_int("p3_led3_new_duty", hi[3], 192);
      run_window(1025, 1'b0, 0, 8'h00, 8'h00);
      check_int("p4_led3_wrap_write_old", hi[3], 192);
      run_window(1281, 1'b0, 0, 8'h00, 8'h00);
      check_int("p5_led3_wrap_write_new", hi[3], 64);

      // Mode switch: DIRECT written at edge 1538, CTRL cleared at edge 1539
      wait_k(1537);
      PORT_ID      = 8'h81;
      OUT_PORT     = 8'h0F;
      WRITE_STROBE = 1'b1;
      @(negedge CLK_IN);
      PORT_ID  = 8'h80;
      OUT_PORT = 8'h00;
      @(negedge CLK_IN);
      WRITE_STROBE = 1'b0;
      @(negedge CLK_IN);
      check8("mode_direct_leds", LEDS, 8'h0F);
      check_int("mode_pwm_cnt_running", int'(dut.pwm_cnt), k % 256);
      wr(8'h80, 8'h01);

      // PWM resumes in phase: LEDS at edge k reflects count (k-1) mod 256
      wait_k(1803);
      check8("resume_phase10", LEDS, 8'h89);
      wait_k(1893);
      check8("resume_phase100", LEDS, 8'h81);
      wait_k(1993);
      check8("resume_phase200", LEDS, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
